// File: rtl/pipe_hazard_pkg.sv
// pipe_hazard_pkg: shared slot record, select encoding and default widths for the hazard unit.
package pipe_hazard_pkg;
    localparam int RF_ADDR_W   = 5;
    localparam int LAT_W       = 3;
    localparam int AGE_W       = 3;
    localparam int NUM_STAGES  = 3;
    localparam int FWD_REGFILE = 0;

    typedef struct packed {
        logic                 valid;
        logic [RF_ADDR_W-1:0] rd;
        logic [LAT_W-1:0]     lat;
        logic [AGE_W-1:0]     age;
    } slot_t;
endpackage

// File: rtl/hazard_operand_resolve.sv
// hazard_operand_resolve: youngest-producer match for one source operand, giving the
// forward select and whether the consumer must wait for an unfinished producer.
module hazard_operand_resolve
    import pipe_hazard_pkg::*;
#(
    parameter int  REGFILE_ADDR_WIDTH = RF_ADDR_W,
    parameter int  NUM_FWD_STAGES     = NUM_STAGES,
    parameter int  SEL_WIDTH          = $clog2(NUM_FWD_STAGES + 1),
    parameter type slot_type          = slot_t
) (
    input  slot_type                      slots [NUM_FWD_STAGES],
    input  logic                          used,
    input  logic [REGFILE_ADDR_WIDTH-1:0] addr,
    output logic [SEL_WIDTH-1:0]          sel,
    output logic                          stall_req
);
    // Walk oldest to youngest so the lowest matching slot has the final say.
    always_comb begin
        sel       = SEL_WIDTH'(FWD_REGFILE);
        stall_req = 1'b0;
        if (used && addr != '0)
            for (int k = NUM_FWD_STAGES - 1; k >= 0; k--)
                if (slots[k].valid && slots[k].rd == addr) begin
                    sel       = (int'(slots[k].age) + 1 >= int'(slots[k].lat)) ? SEL_WIDTH'(k + 1) : SEL_WIDTH'(FWD_REGFILE);
                    stall_req = int'(slots[k].age) + 1 < int'(slots[k].lat);
                end
    end
endmodule

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: shadow pipeline of in-flight writes, operand forwarding selects and ID stall.
// Optional HAZARD_PERF_EN adds Stall_cycles / Fwd_hits performance counters.
module pipe_hazard_unit
    import pipe_hazard_pkg::*;
#(
    parameter int REGFILE_ADDR_WIDTH = RF_ADDR_W,
    parameter int NUM_FWD_STAGES     = NUM_STAGES,
    parameter int LAT_WIDTH          = LAT_W,
    parameter int SEL_WIDTH          = $clog2(NUM_FWD_STAGES + 1)
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic                          ID_Valid,
    input  logic [REGFILE_ADDR_WIDTH-1:0] ID_Rs1_addr,
    input  logic [REGFILE_ADDR_WIDTH-1:0] ID_Rs2_addr,
    input  logic [1:0]                    ID_Rs_used,
    input  logic [REGFILE_ADDR_WIDTH-1:0] ID_Rd_addr,
    input  logic                          ID_RegFile_wr_en,
    input  logic [LAT_WIDTH-1:0]          ID_Rd_lat,
    input  logic                          EX_Flush,
    output logic [SEL_WIDTH-1:0]          ForwardA,
    output logic [SEL_WIDTH-1:0]          ForwardB,
    output logic                          Stall
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]                   Stall_cycles,
    output logic [31:0]                   Fwd_hits
`endif
);
    typedef struct packed {
        logic                          valid;
        logic [REGFILE_ADDR_WIDTH-1:0] rd;
        logic [LAT_WIDTH-1:0]          lat;
        logic [AGE_W-1:0]              age;
    } slot_p_t;

    slot_p_t              slots [NUM_FWD_STAGES];
    logic                 stall_a, stall_b;
    logic [LAT_WIDTH-1:0] lat_eff;

    assign lat_eff = (ID_Rd_lat == '0) ? LAT_WIDTH'(1) : ID_Rd_lat;
    assign Stall   = ID_Valid & (stall_a | stall_b);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int k = 0; k < NUM_FWD_STAGES; k++)
                slots[k] <= '0;
        end else begin
            slots[0] <= '{valid: ID_Valid & ID_RegFile_wr_en & (ID_Rd_addr != '0) & ~Stall & ~EX_Flush,
                          rd: ID_Rd_addr, lat: lat_eff, age: '0};
            for (int k = 1; k < NUM_FWD_STAGES; k++)
                slots[k] <= '{valid: slots[k-1].valid, rd: slots[k-1].rd, lat: slots[k-1].lat,
                              age: (slots[k-1].age >= AGE_W'(NUM_FWD_STAGES)) ? slots[k-1].age : slots[k-1].age + 1'b1};
        end
    end

    hazard_operand_resolve #(
        .REGFILE_ADDR_WIDTH(REGFILE_ADDR_WIDTH), .NUM_FWD_STAGES(NUM_FWD_STAGES),
        .SEL_WIDTH(SEL_WIDTH), .slot_type(slot_p_t)
    ) u_res_a (
        .slots(slots), .used(ID_Rs_used[0]), .addr(ID_Rs1_addr), .sel(ForwardA), .stall_req(stall_a)
    );

    hazard_operand_resolve #(
        .REGFILE_ADDR_WIDTH(REGFILE_ADDR_WIDTH), .NUM_FWD_STAGES(NUM_FWD_STAGES),
        .SEL_WIDTH(SEL_WIDTH), .slot_type(slot_p_t)
    ) u_res_b (
        .slots(slots), .used(ID_Rs_used[1]), .addr(ID_Rs2_addr), .sel(ForwardB), .stall_req(stall_b)
    );

`ifdef HAZARD_PERF_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Stall_cycles <= '0;
            Fwd_hits     <= '0;
        end else begin
            Stall_cycles <= Stall_cycles + 32'(Stall);
            Fwd_hits     <= Fwd_hits + 32'(ForwardA != '0) + 32'(ForwardB != '0);
        end
    end
`endif
endmodule
